// File: rtl/block_reader.sv
// Raster frame -> 8x8 block sequencer: reads the frame memory in block order and streams 12-bit samples to the row DCT.
// Memory read data to S_out_o is 1 cycle; each 8-sample row burst starts only after rdy_in_i is seen high in WAIT.
module block_reader #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int ADDR_W = 19
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rden_o,
  input  logic [11:0]       mem_data_i,
  input  logic              rdy_in_i,
  output logic              ena_out_o,
  output logic [11:0]       S_out_o
);

  localparam int BX_N = WIDTH / 8;
  localparam int BY_N = HEIGHT / 8;
  localparam int BXW  = (BX_N > 1) ? $clog2(BX_N) : 1;
  localparam int BYW  = (BY_N > 1) ? $clog2(BY_N) : 1;

  localparam logic [BXW-1:0] BX_LAST = BXW'(BX_N - 1);
  localparam logic [BYW-1:0] BY_LAST = BYW'(BY_N - 1);

  // Row-base increments; BLK_STEP is negative and relies on modular wrap.
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(WIDTH);
  localparam logic [ADDR_W-1:0] BLK_STEP  = ADDR_W'(8 - 7 * WIDTH);
  localparam logic [ADDR_W-1:0] BROW_STEP = ADDR_W'(8);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_BURST  = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [2:0]        c_q, c_d;
  logic [2:0]        r_q, r_d;
  logic [BXW-1:0]    bx_q, bx_d;
  logic [BYW-1:0]    by_q, by_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ena_q, ena_d;

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    r_d     = r_q;
    bx_d    = bx_q;
    by_d    = by_q;
    base_d  = base_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ena_d   = (state_q == S_BURST);

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_WAIT;
          c_d     = 3'd0;
          r_d     = 3'd0;
          bx_d    = '0;
          by_d    = '0;
          base_d  = '0;
          busy_d  = 1'b1;
        end
      end

      S_WAIT: begin
        if (rdy_in_i) begin
          state_d = S_BURST;
          c_d     = 3'd0;
        end
      end

      S_BURST: begin
        c_d = c_q + 3'd1;
        // rdy_in_i is deliberately ignored here: a started row always completes.
        if (c_q == 3'd7) begin
          c_d     = 3'd0;
          state_d = S_WAIT;
          if (r_q != 3'd7) begin
            r_d    = r_q + 3'd1;
            base_d = base_q + ROW_STEP;
          end else if (bx_q != BX_LAST) begin
            r_d    = 3'd0;
            bx_d   = bx_q + 1'b1;
            base_d = base_q + BLK_STEP;
          end else if (by_q != BY_LAST) begin
            // Last row of the rightmost block sits just before the next block row.
            r_d    = 3'd0;
            bx_d   = '0;
            by_d   = by_q + 1'b1;
            base_d = base_q + BROW_STEP;
          end else begin
            state_d = S_FINISH;
          end
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      c_q     <= 3'd0;
      r_q     <= 3'd0;
      bx_q    <= '0;
      by_q    <= '0;
      base_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ena_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      r_q     <= r_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      base_q  <= base_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ena_q   <= ena_d;
    end
  end

  assign mem_rden_o = (state_q == S_BURST);
  assign mem_addr_o = mem_rden_o ? (base_q + ADDR_W'(c_q)) : '0;
  assign ena_out_o  = ena_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign S_out_o    = mem_data_i;

endmodule

// File: tb/tb_block_reader.sv
// Bench for block_reader: three frame geometries (16x8, 8x8, 16x16) driven in lockstep and checked against a block-order address model.
module tb_block_reader;

  localparam int NI   = 3;
  localparam int LOGN = 2048;

  logic clk = 1'b0;
  logic rst, start, rdy;

  logic        busy[NI], done[NI], rden[NI], ena[NI];
  logic [18:0] addr[NI];
  logic [11:0] mdata[NI], sout[NI];

  logic [11:0] mem[0:255];
  int          cyc = 0;
  logic        rdy_drv[0:16383];

  logic [18:0] alog[NI][0:LOGN-1];
  int          acyc[NI][0:LOGN-1];
  logic [11:0] elog[NI][0:LOGN-1];
  int          ecyc[NI][0:LOGN-1];
  int          acnt[NI] = '{default: 0};
  int          ecnt[NI] = '{default: 0};
  int          dcnt[NI] = '{default: 0};
  int          dcyc[NI] = '{default: 0};
  logic        dbusy[NI];

  int ab[NI], eb[NI], db[NI];
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  block_reader #(.WIDTH(16), .HEIGHT(8), .ADDR_W(19)) u_r0 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy[0]), .done_o(done[0]),
    .mem_addr_o(addr[0]), .mem_rden_o(rden[0]), .mem_data_i(mdata[0]), .rdy_in_i(rdy),
    .ena_out_o(ena[0]), .S_out_o(sout[0]));

  block_reader #(.WIDTH(8), .HEIGHT(8), .ADDR_W(19)) u_r1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy[1]), .done_o(done[1]),
    .mem_addr_o(addr[1]), .mem_rden_o(rden[1]), .mem_data_i(mdata[1]), .rdy_in_i(rdy),
    .ena_out_o(ena[1]), .S_out_o(sout[1]));

  block_reader #(.WIDTH(16), .HEIGHT(16), .ADDR_W(19)) u_r2 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy[2]), .done_o(done[2]),
    .mem_addr_o(addr[2]), .mem_rden_o(rden[2]), .mem_data_i(mdata[2]), .rdy_in_i(rdy),
    .ena_out_o(ena[2]), .S_out_o(sout[2]));

  // Frame memory with one cycle of read latency.
  always @(posedge clk) begin
    for (int k = 0; k < NI; k++)
      if (rden[k] === 1'b1) mdata[k] <= mem[addr[k][7:0]];
  end

  // rdy_drv[m] is the rdy value the DUTs sample at posedge m+1.
  always @(posedge clk) begin
    if (cyc < 16384) rdy_drv[cyc] <= rdy;
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (rden[k] === 1'b1 && acnt[k] < LOGN) begin
        alog[k][acnt[k]] = addr[k];
        acyc[k][acnt[k]] = cyc;
        acnt[k]++;
      end
      if (ena[k] === 1'b1 && ecnt[k] < LOGN) begin
        elog[k][ecnt[k]] = sout[k];
        ecyc[k][ecnt[k]] = cyc;
        ecnt[k]++;
      end
      if (done[k] === 1'b1) begin
        dcnt[k]++;
        dcyc[k]  = cyc;
        dbusy[k] = busy[k];
      end
    end
  end

  function automatic int wk(input int k);
    case (k)
      0:       return 16;
      1:       return 8;
      default: return 16;
    endcase
  endfunction

  function automatic int hk(input int k);
    case (k)
      0:       return 8;
      1:       return 8;
      default: return 16;
    endcase
  endfunction

  // Address of the n-th sample delivered: blocks left-to-right then top-to-bottom, row-major inside.
  function automatic int exp_addr(input int k, input int n);
    int w, bpr, blk, r, c;
    w   = wk(k);
    bpr = w / 8;
    blk = n / 64;
    r   = (n / 8) % 8;
    c   = n % 8;
    return ((blk / bpr) * 8 + r) * w + (blk % bpr) * 8 + c;
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic mark();
    for (int k = 0; k < NI; k++) begin
      ab[k] = acnt[k];
      eb[k] = ecnt[k];
      db[k] = dcnt[k];
    end
  endtask

  task automatic pulse_start(output int a);
    start = 1'b1;
    a     = cyc;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_all_done(input int budget, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (dcnt[0] > db[0] && dcnt[1] > db[1] && dcnt[2] > db[2]) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
    n_checks++;
    if (!ok) $display("FAIL %s_timeout: done seen %0d/%0d/%0d, required 1 each", tag,
                      dcnt[0] - db[0], dcnt[1] - db[1], dcnt[2] - db[2]);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; rdy = 1'b0;
    step(3);
    for (int k = 0; k < NI; k++) begin
      n_checks++; if (busy[k] !== 1'b0) $display("FAIL reset_busy[%0d]: got %b want 0", k, busy[k]); else n_pass++;
      n_checks++; if (done[k] !== 1'b0) $display("FAIL reset_done[%0d]: got %b want 0", k, done[k]); else n_pass++;
      n_checks++; if (rden[k] !== 1'b0) $display("FAIL reset_rden[%0d]: got %b want 0", k, rden[k]); else n_pass++;
      n_checks++; if (ena[k] !== 1'b0) $display("FAIL reset_ena[%0d]: got %b want 0", k, ena[k]); else n_pass++;
      n_checks++; if (addr[k] !== 19'd0) $display("FAIL reset_addr[%0d]: got %0d want 0", k, addr[k]); else n_pass++;
    end
    rst = 1'b0;
    step(4);
    for (int k = 0; k < NI; k++) begin
      n_checks++; if ({busy[k], rden[k]} !== 2'b00) $display("FAIL idle_after_reset[%0d]: busy/rden %b want 00", k, {busy[k], rden[k]}); else n_pass++;
    end
  endtask

  task automatic test_frame();
    int a, nn, e, ia, ie, last;
    mark();
    rdy = 1'b1;
    pulse_start(a);
    for (int k = 0; k < NI; k++) begin
      n_checks++; if (busy[k] !== 1'b1) $display("FAIL frame_busy_rise[%0d]: got %b want 1", k, busy[k]); else n_pass++;
    end
    wait_all_done(1500, "frame");
    step(3);
    for (int k = 0; k < NI; k++) begin
      nn = wk(k) * hk(k);
      n_checks++; if (acnt[k] - ab[k] != nn) $display("FAIL frame_rden_count[%0d]: got %0d want %0d", k, acnt[k] - ab[k], nn); else n_pass++;
      n_checks++; if (ecnt[k] - eb[k] != nn) $display("FAIL frame_ena_count[%0d]: got %0d want %0d", k, ecnt[k] - eb[k], nn); else n_pass++;
      n_checks++; if (dcnt[k] - db[k] != 1) $display("FAIL frame_done_count[%0d]: got %0d want 1", k, dcnt[k] - db[k]); else n_pass++;
      for (int n = 0; n < nn && n < acnt[k] - ab[k]; n++) begin
        e  = exp_addr(k, n);
        ia = ab[k] + n;
        n_checks++; if (alog[k][ia] !== e[18:0]) $display("FAIL frame_addr[%0d][%0d]: got %0d want %0d", k, n, alog[k][ia], e); else n_pass++;
        n_checks++; if (acyc[k][ia] != a + 2 + 9 * (n / 8) + n % 8) $display("FAIL frame_rden_cycle[%0d][%0d]: got %0d want %0d", k, n, acyc[k][ia], a + 2 + 9 * (n / 8) + n % 8); else n_pass++;
      end
      for (int n = 0; n < nn && n < ecnt[k] - eb[k]; n++) begin
        e  = exp_addr(k, n);
        ie = eb[k] + n;
        n_checks++; if (elog[k][ie] !== mem[e[7:0]]) $display("FAIL frame_sample[%0d][%0d]: got %h want %h", k, n, elog[k][ie], mem[e[7:0]]); else n_pass++;
        n_checks++; if (ecyc[k][ie] != a + 3 + 9 * (n / 8) + n % 8) $display("FAIL frame_ena_cycle[%0d][%0d]: got %0d want %0d", k, n, ecyc[k][ie], a + 3 + 9 * (n / 8) + n % 8); else n_pass++;
      end
      // First WAIT is at a+1; the last read closes (rows * 9) cycles later.
      last = a + (nn / 8) * 9;
      n_checks++; if (dcyc[k] != last + 2) $display("FAIL frame_done_cycle[%0d]: got %0d want %0d", k, dcyc[k], last + 2); else n_pass++;
      n_checks++; if (dbusy[k] !== 1'b0) $display("FAIL frame_busy_at_done[%0d]: got %b want 0", k, dbusy[k]); else n_pass++;
    end
  endtask

  task automatic test_rdy_stall();
    int a;
    mark();
    rdy = 1'b0;
    pulse_start(a);
    while (cyc < a + 20) step(1);
    rdy = 1'b1;
    step(12);
    for (int k = 0; k < NI; k++) begin
      n_checks++; if (acnt[k] - ab[k] < 8) $display("FAIL stall_count[%0d]: got %0d reads want >=8", k, acnt[k] - ab[k]); else n_pass++;
      for (int i = 0; i < 8; i++) begin
        n_checks++; if (alog[k][ab[k] + i] !== 19'(i)) $display("FAIL stall_addr[%0d][%0d]: got %0d want %0d", k, i, alog[k][ab[k] + i], i); else n_pass++;
        n_checks++; if (acyc[k][ab[k] + i] != a + 21 + i) $display("FAIL stall_cycle[%0d][%0d]: got %0d want %0d", k, i, acyc[k][ab[k] + i], a + 21 + i); else n_pass++;
      end
    end
    wait_all_done(1500, "stall");
    step(3);
    for (int k = 0; k < NI; k++) begin
      n_checks++; if (dcnt[k] - db[k] != 1) $display("FAIL stall_done_count[%0d]: got %0d want 1", k, dcnt[k] - db[k]); else n_pass++;
    end
  endtask

  task automatic test_rdy_pulse();
    int a, c1, e;
    mark();
    rdy = 1'b0;
    pulse_start(a);
    while (cyc < a + 3) step(1);
    rdy = 1'b1;
    step(1);
    rdy = 1'b0;
    step(30);
    for (int k = 0; k < NI; k++) begin
      n_checks++; if (acnt[k] - ab[k] != 8) $display("FAIL pulse_rden_count[%0d]: got %0d want 8", k, acnt[k] - ab[k]); else n_pass++;
      n_checks++; if (ecnt[k] - eb[k] != 8) $display("FAIL pulse_ena_count[%0d]: got %0d want 8", k, ecnt[k] - eb[k]); else n_pass++;
      for (int i = 0; i < 8; i++) begin
        n_checks++; if (acyc[k][ab[k] + i] != a + 4 + i) $display("FAIL pulse_cycle[%0d][%0d]: got %0d want %0d", k, i, acyc[k][ab[k] + i], a + 4 + i); else n_pass++;
      end
    end
    c1  = cyc;
    rdy = 1'b1;
    step(12);
    for (int k = 0; k < NI; k++) begin
      e = exp_addr(k, 8);
      n_checks++; if (acnt[k] - ab[k] < 9) $display("FAIL pulse_second_count[%0d]: got %0d want >=9", k, acnt[k] - ab[k]); else n_pass++;
      n_checks++; if (acyc[k][ab[k] + 8] != c1 + 1) $display("FAIL pulse_second_cycle[%0d]: got %0d want %0d", k, acyc[k][ab[k] + 8], c1 + 1); else n_pass++;
      n_checks++; if (alog[k][ab[k] + 8] !== e[18:0]) $display("FAIL pulse_second_addr[%0d]: got %0d want %0d", k, alog[k][ab[k] + 8], e); else n_pass++;
    end
    wait_all_done(1500, "pulse");
    step(3);
    for (int k = 0; k < NI; k++) begin
      n_checks++; if (dcnt[k] - db[k] != 1) $display("FAIL pulse_done_count[%0d]: got %0d want 1", k, dcnt[k] - db[k]); else n_pass++;
    end
  endtask

  // Random rdy plus extra start pulses while busy; burst timing predicted from the recorded rdy history.
  task automatic test_random_rdy();
    int  a, nn, prev, m, s, n, e;
    bit  ok;
    mark();
    rdy = 1'($urandom_range(0, 1));
    pulse_start(a);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (dcnt[0] > db[0] && dcnt[1] > db[1] && dcnt[2] > db[2]) begin
        ok = 1'b1;
        break;
      end
      rdy   = 1'($urandom_range(0, 1));
      start = (i == 10 || i == 40);
      step(1);
    end
    start = 1'b0;
    rdy   = 1'b0;
    n_checks++; if (!ok) $display("FAIL random_timeout: done not seen on all instances"); else n_pass++;
    step(5);
    for (int k = 0; k < NI; k++) begin
      nn   = wk(k) * hk(k);
      prev = a;
      n_checks++; if (acnt[k] - ab[k] != nn) $display("FAIL random_rden_count[%0d]: got %0d want %0d", k, acnt[k] - ab[k], nn); else n_pass++;
      for (int b = 0; b < nn / 8; b++) begin
        m = prev + 1;
        while (m < cyc && rdy_drv[m] !== 1'b1) m++;
        s = m + 1;
        for (int i = 0; i < 8; i++) begin
          n = b * 8 + i;
          e = exp_addr(k, n);
          if (n < acnt[k] - ab[k]) begin
            n_checks++; if (alog[k][ab[k] + n] !== e[18:0]) $display("FAIL random_addr[%0d][%0d]: got %0d want %0d", k, n, alog[k][ab[k] + n], e); else n_pass++;
            n_checks++; if (acyc[k][ab[k] + n] != s + i) $display("FAIL random_rden_cycle[%0d][%0d]: got %0d want %0d", k, n, acyc[k][ab[k] + n], s + i); else n_pass++;
          end
          if (n < ecnt[k] - eb[k]) begin
            n_checks++; if (elog[k][eb[k] + n] !== mem[e[7:0]]) $display("FAIL random_sample[%0d][%0d]: got %h want %h", k, n, elog[k][eb[k] + n], mem[e[7:0]]); else n_pass++;
            n_checks++; if (ecyc[k][eb[k] + n] != s + i + 1) $display("FAIL random_ena_cycle[%0d][%0d]: got %0d want %0d", k, n, ecyc[k][eb[k] + n], s + i + 1); else n_pass++;
          end
        end
        prev = s + 7;
      end
      n_checks++; if (dcnt[k] - db[k] != 1) $display("FAIL random_done_count[%0d]: got %0d want 1", k, dcnt[k] - db[k]); else n_pass++;
      n_checks++; if (dcyc[k] != prev + 2) $display("FAIL random_done_cycle[%0d]: got %0d want %0d", k, dcyc[k], prev + 2); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_burst();
    int a, a2, e;
    mark();
    rdy = 1'b1;
    pulse_start(a);
    while (cyc < a + 5) step(1);
    n_checks++; if ({rden[0], addr[0]} !== {1'b1, 19'd3}) $display("FAIL midrst_precheck: rden/addr %b/%0d want 1/3", rden[0], addr[0]); else n_pass++;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    for (int k = 0; k < NI; k++) begin
      n_checks++; if (rden[k] !== 1'b0) $display("FAIL midrst_rden[%0d]: got %b want 0", k, rden[k]); else n_pass++;
      n_checks++; if (ena[k] !== 1'b0) $display("FAIL midrst_ena[%0d]: got %b want 0", k, ena[k]); else n_pass++;
      n_checks++; if (busy[k] !== 1'b0) $display("FAIL midrst_busy[%0d]: got %b want 0", k, busy[k]); else n_pass++;
      n_checks++; if (addr[k] !== 19'd0) $display("FAIL midrst_addr[%0d]: got %0d want 0", k, addr[k]); else n_pass++;
    end
    step(20);
    for (int k = 0; k < NI; k++) begin
      n_checks++; if (dcnt[k] - db[k] != 0) $display("FAIL midrst_no_done[%0d]: got %0d want 0", k, dcnt[k] - db[k]); else n_pass++;
      n_checks++; if (acnt[k] - ab[k] != 4) $display("FAIL midrst_reads[%0d]: got %0d want 4", k, acnt[k] - ab[k]); else n_pass++;
    end
    mark();
    pulse_start(a2);
    step(10);
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 8; i++) begin
        e = exp_addr(k, i);
        n_checks++; if (alog[k][ab[k] + i] !== e[18:0]) $display("FAIL restart_addr[%0d][%0d]: got %0d want %0d", k, i, alog[k][ab[k] + i], e); else n_pass++;
        n_checks++; if (acyc[k][ab[k] + i] != a2 + 2 + i) $display("FAIL restart_cycle[%0d][%0d]: got %0d want %0d", k, i, acyc[k][ab[k] + i], a2 + 2 + i); else n_pass++;
      end
    end
    wait_all_done(1500, "restart");
    step(3);
    for (int k = 0; k < NI; k++) begin
      n_checks++; if (dcnt[k] - db[k] != 1) $display("FAIL restart_done_count[%0d]: got %0d want 1", k, dcnt[k] - db[k]); else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rdy = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 12'($urandom);
    test_reset();
    test_frame();
    step(3);
    test_rdy_stall();
    step(3);
    test_rdy_pulse();
    step(3);
    test_random_rdy();
    step(3);
    test_reset_mid_burst();
    step(3);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
